// File: rtl/prim_rec_iter_multi_if.sv
// Start/ready handshake and operand bus of the primitive-recursion iterator.
interface prim_rec_iter_multi_if #(
  parameter int BW = 16
);
  logic          ST;
  logic          RD;
  logic [BW-1:0] RES;
  logic          OVF;
  logic [1:0]    MODE;
  logic [BW-1:0] IN0;
  logic [BW-1:0] IN1;

  modport master (output ST, MODE, IN0, IN1, input RD, RES, OVF);
  modport slave  (input ST, MODE, IN0, IN1, output RD, RES, OVF);
endinterface

// File: rtl/prim_rec_iter_multi.sv
// Iterative f(x,0)=g(x), f(x,k+1)=h(x,k,f) for MUL/POW/TRI/PROJ; RD drops while busy, starts ignored then.
// Latency E(N+2) for MUL/TRI, E(2+N*(BW+1)) for POW; PRIMREC_SAT_EN clamps overflowing steps to all-ones.
module prim_rec_iter_multi #(
  parameter int BW = 16
) (
  input logic CLK,
  input logic RST,
  prim_rec_iter_multi_if.slave bus
);

  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_MULT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] MODE_MUL  = 2'b00;
  localparam logic [1:0] MODE_POW  = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_PROJ = 2'b11;

  logic [2:0]      state;
  logic            st_old;
  logic            rd;
  logic            ovf;
  logic [BW-1:0]   res;
  logic [BW-1:0]   acc;
  logic [BW-1:0]   cnt;
  logic [BW-1:0]   x;
  logic [BW-1:0]   n;
  logic [1:0]      m;
  logic [BW-1:0]   mcand;
  logic [BW-1:0]   mplier;
  logic [2*BW-1:0] prod;
  logic [BCW-1:0]  bitcnt;

  logic            start;
  logic [BW-1:0]   add_op;
  logic [BW:0]     add_full;
  logic            add_ovf;
  logic [BW-1:0]   add_val;
  logic [2*BW-1:0] term;
  logic [2*BW-1:0] prod_nxt;
  logic            mul_ovf;
  logic [BW-1:0]   mul_val;
  logic [BW-1:0]   g_val;

  // DONE already shows RD=1, so it accepts a fresh start exactly like IDLE.
  assign start = bus.ST & ~st_old & ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    add_op   = (m == MODE_TRI) ? cnt : x;
    add_full = {1'b0, acc} + {1'b0, add_op};
    add_ovf  = add_full[BW];
    term     = mplier[bitcnt] ? ({{BW{1'b0}}, mcand} << bitcnt) : '0;
    prod_nxt = prod + term;
    mul_ovf  = |prod_nxt[2*BW-1:BW];
`ifdef PRIMREC_SAT_EN
    add_val  = add_ovf ? '1 : add_full[BW-1:0];
    mul_val  = mul_ovf ? '1 : prod_nxt[BW-1:0];
`else
    add_val  = add_full[BW-1:0];
    mul_val  = prod_nxt[BW-1:0];
`endif
    case (m)
      MODE_POW:  g_val = {{(BW-1){1'b0}}, 1'b1};
      MODE_PROJ: g_val = x;
      default:   g_val = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      st_old <= 1'b0;
      rd     <= 1'b1;
      ovf    <= 1'b0;
      res    <= '0;
      acc    <= '0;
      cnt    <= '0;
      x      <= '0;
      n      <= '0;
      m      <= MODE_MUL;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      bitcnt <= '0;
    end else begin
      st_old <= bus.ST;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            x     <= bus.IN0;
            n     <= (bus.MODE == MODE_PROJ) ? '0 : bus.IN1;
            m     <= bus.MODE;
            rd    <= 1'b0;
            ovf   <= 1'b0;
            state <= S_INIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_INIT: begin
          acc   <= g_val;
          cnt   <= '0;
          state <= S_STEP;
        end
        S_STEP: begin
          if (cnt == n) begin
            res   <= acc;
            rd    <= 1'b1;
            state <= S_DONE;
          end else if (m == MODE_POW) begin
            mcand  <= acc;
            mplier <= x;
            prod   <= '0;
            bitcnt <= '0;
            state  <= S_MULT;
          end else begin
            // PROJ never reaches here since its N is forced to 0.
            acc <= add_val;
            cnt <= cnt + BW'(1);
            if (add_ovf) ovf <= 1'b1;
          end
        end
        S_MULT: begin
          prod   <= prod_nxt;
          bitcnt <= bitcnt + BCW'(1);
          if (bitcnt == BCW'(BW-1)) begin
            acc   <= mul_val;
            cnt   <= cnt + BW'(1);
            if (mul_ovf) ovf <= 1'b1;
            state <= S_STEP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.RD  = rd;
  assign bus.RES = res;
  assign bus.OVF = ovf;

endmodule

// File: tb/tb_prim_rec_iter_multi.sv
// Scoreboard bench: driver queues expected result/OVF/latency per start, monitor checks on each RD rise.
module tb_prim_rec_iter_multi;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;

  prim_rec_iter_multi_if #(.BW(16)) bus();

  prim_rec_iter_multi #(.BW(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
    int          e0;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   ign_rise = 1'b0;
  logic rd_q = 1'b1;

`ifdef PRIMREC_SAT_EN
  localparam logic [15:0] POW_OVF_RES = 16'hFFFF;
  localparam logic [15:0] MUL_OVF_RES = 16'hFFFF;
`else
  localparam logic [15:0] POW_OVF_RES = 16'h0000;
  localparam logic [15:0] MUL_OVF_RES = 16'd54464;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, want);
    end
  endtask

  // Monitor: every RD rise outside an intentional reset consumes one expectation.
  always @(negedge CLK) begin
    if (rd_q === 1'b0 && bus.RD === 1'b1) begin
      if (ign_rise) begin
        ign_rise = 1'b0;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res", {16'd0, bus.RES}, {16'd0, e.res});
        chk("ovf", {31'd0, bus.OVF}, {31'd0, e.ovf});
        chk("latency", cyc - e.e0, e.lat);
      end
    end
    rd_q = bus.RD;
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (bus.RD === 1'b1 && exp_q.size() == 0) break;
      @(posedge CLK); #1;
    end
    if (i == 3000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drives one start; returns at E0+#1 when hold==1.
  task automatic issue(input logic [1:0] mode, input logic [15:0] in0, input logic [15:0] in1,
                       input logic [15:0] r, input logic o, input int lat,
                       input bit push, input int hold);
    exp_t e;
    wait_idle();
    @(posedge CLK); #1;
    bus.MODE = mode;
    bus.IN0  = in0;
    bus.IN1  = in1;
    bus.ST   = 1'b1;
    e.res = r; e.ovf = o; e.lat = lat; e.e0 = cyc + 1;
    if (push) exp_q.push_back(e);
    @(posedge CLK); #1;
    chk("rd_busy", {31'd0, bus.RD}, 32'd0);
    repeat (hold - 1) begin
      @(posedge CLK); #1;
    end
    bus.ST = 1'b0;
  endtask

  initial begin
    bus.ST = 1'b0; bus.MODE = 2'b00; bus.IN0 = '0; bus.IN1 = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rd",  {31'd0, bus.RD},  32'd1);
    chk("rst_res", {16'd0, bus.RES}, 32'd0);
    chk("rst_ovf", {31'd0, bus.OVF}, 32'd0);
    RST = 1'b0;

    issue(2'b00, 16'd7,      16'd5,  16'd35,      1'b0, 7,  1, 1);
    issue(2'b01, 16'd3,      16'd4,  16'd81,      1'b0, 70, 1, 1);
    issue(2'b10, 16'd99,     16'd10, 16'd45,      1'b0, 12, 1, 1);
    issue(2'b00, 16'd9,      16'd0,  16'd0,       1'b0, 2,  1, 1);
    issue(2'b01, 16'd5,      16'd0,  16'd1,       1'b0, 2,  1, 1);
    issue(2'b11, 16'h1234,   16'd50, 16'h1234,    1'b0, 2,  1, 1);
    issue(2'b01, 16'd256,    16'd3,  POW_OVF_RES, 1'b1, 53, 1, 1);
    issue(2'b00, 16'd2,      16'd3,  16'd6,       1'b0, 5,  1, 1);
    issue(2'b00, 16'd60000,  16'd2,  MUL_OVF_RES, 1'b1, 4,  1, 1);

    // ST held high for 20 cycles must launch exactly one operation.
    issue(2'b00, 16'd100, 16'd10, 16'd1000, 1'b0, 12, 1, 20);
    repeat (10) @(posedge CLK);
    #1;

    // A second pulse at E3 with new operands is ignored; operands stay latched.
    issue(2'b00, 16'd7, 16'd5, 16'd35, 1'b0, 7, 1, 1);
    @(posedge CLK); @(posedge CLK); #1;
    bus.ST = 1'b1; bus.IN0 = 16'd1; bus.IN1 = 16'd1; bus.MODE = 2'b01;
    @(posedge CLK); #1;
    bus.ST = 1'b0;
    wait_idle();
    repeat (10) @(posedge CLK);
    #1;

    // Reset asserted at E3 aborts the operation.
    issue(2'b00, 16'd7, 16'd5, 16'd0, 1'b0, 0, 0, 1);
    ign_rise = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_rd",  {31'd0, bus.RD},  32'd1);
    chk("abort_res", {16'd0, bus.RES}, 32'd0);
    chk("abort_ovf", {31'd0, bus.OVF}, 32'd0);
    issue(2'b00, 16'd7, 16'd5, 16'd35, 1'b0, 7, 1, 1);

    wait_idle();
    repeat (30) @(posedge CLK);
    #1;
    chk("leftover_expect", exp_q.size(), 32'd0);
    chk("final_rd", {31'd0, bus.RD}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

endmodule
